fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Holds the program counter and drives it to the PC+4 adder and the instruction memory.
- Consumes the adder's sum and the fetched instruction, then registers both into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects from EX, and instruction-memory wait cycles.

Parameters:
- WIDTH, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction inserted into IF/ID as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pc_out  out  WIDTH  current PC; drives PC adder in1 and imem address.
- pc_plus4_in  in  WIDTH  PC adder out (pc_out+4, in2 tied to 4 externally).
- imem_req  out  1  fetch request to instruction memory.
- imem_rdata  in  32  instruction at pc_out.
- imem_valid  in  1  imem_rdata valid this cycle.
- stall  in  1  hazard unit: freeze PC and IF/ID.
- redirect  in  1  taken branch or jump resolved in EX.
- redirect_target  in  WIDTH  new PC for a redirect.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc_plus4  out  WIDTH  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- misalign_err  out  1  sticky: a redirect target had bits[1:0] != 0.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- While reset is high:
  - pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, misalign_err=0.
  - State=BOOT, imem_req=0.
- FSM states:
  - BOOT: imem_req=0, no fetch, PC holds. Next state is always RUN. A redirect in BOOT still loads the PC; IF/ID stays a bubble.
  - RUN: imem_req=1 every cycle. No return to BOOT except via reset.
- RUN update, evaluated at each posedge clk, priority highest first:
  1. redirect=1: pc <= {redirect_target[WIDTH-1:2],2'b00}; IF/ID <= bubble (NOP_INSTR, pc_plus4=0, valid=0). Redirect overrides stall and imem_valid, since the wrong-path fetch is discarded.
  2. stall=1: pc and all IF/ID outputs hold their values.
  3. imem_valid=0: pc holds; IF/ID <= bubble.
  4. Otherwise: pc <= pc_plus4_in; ifid_instr <= imem_rdata; ifid_pc_plus4 <= pc_plus4_in; ifid_valid <= 1.
- misalign_err: set on any cycle with redirect=1 and redirect_target[1:0]!=0, in BOOT or RUN. Cleared only by reset.
- Latency: an instruction at PC appears on ifid_* one cycle after it is fetched with imem_valid=1. A redirect produces its first target instruction in IF/ID two cycles later, with one bubble in between.
- Arithmetic: no addition inside this block; PC+4 comes only from pc_plus4_in. Wrap-around at 32'hFFFF_FFFC -> 0 is inherited from the adder and accepted silently.
- Combinational paths: pc_out, imem_req and ifid_* are registered outputs. There is no combinational path from any input to any output.
- Reset asserted mid-operation: all outputs return to their reset values immediately, without waiting for the clock edge.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR and RESET_PC constants.
  - Fetch FSM state encoding (BOOT=1'b0, RUN=1'b1).
  - WIDTH constant, reused by the PC adder and the ID stage.
- One sub-module, if_id_reg: the IF/ID pipeline register.
  - Inputs: load, hold, bubble; asynchronous reset.
  - Reused by the ID-stage integration.
- The PC register and FSM stay in fetch_stage.

Test Plan:
- Reset then sequential fetch: reset high, then low. Cycle 1 is BOOT: pc=0, imem_req=0. Then, with imem_valid=1, pc_out steps 0,4,8,12. ifid_pc_plus4 steps 4,8,12 one cycle later; ifid_valid=1 from the third cycle.
- Stall: at pc=8, stall=1 for 2 cycles -> pc_out stays 8 and ifid_* stay frozen. After release, pc=12 and the instr@8 enters IF/ID.
- Redirect during stall: pc=16, stall=1 and redirect=1 with target 32'h40 -> next cycle pc=0x40, ifid_valid=0, ifid_instr=NOP. The cycle after, ifid_pc_plus4=0x44.
- imem wait: imem_valid=0 for 3 cycles at pc=0x20 -> pc holds at 0x20 and IF/ID shows 3 bubbles. Then valid=1 -> ifid_instr=rdata and ifid_pc_plus4=0x24.
- Misaligned redirect: target 32'h103 -> pc=0x100 and misalign_err=1. It stays 1 through later redirects and clears only on reset.
- Asynchronous reset mid-run: pc=0x2C, then assert reset between clock edges -> pc_out=0 and ifid_valid=0 before the next posedge. After release, one BOOT cycle with imem_req=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset/bubble constants and the fetch FSM encoding.
package cpu_pkg;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // A word address must have its two low bits clear.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold beats load; otherwise contents are kept.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int          W   = 32,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         hold,
  input  logic         bubble,
  input  logic [31:0]  next_instr,
  input  logic [W-1:0] next_pc_plus4,
  output logic [31:0]  instr,
  output logic [W-1:0] pc_plus4,
  output logic         valid
);

  logic [31:0]  instr_r;
  logic [W-1:0] pc_plus4_r;
  logic         valid_r;

  // IF/ID contents update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r    <= NOP;
      pc_plus4_r <= '0;
      valid_r    <= 1'b0;
    end else if (bubble) begin
      instr_r    <= NOP;
      pc_plus4_r <= '0;
      valid_r    <= 1'b0;
    end else if (hold) begin
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
    end else if (load) begin
      instr_r    <= next_instr;
      pc_plus4_r <= next_pc_plus4;
      valid_r    <= 1'b1;
    end else begin
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
    end
  end

  assign instr    = instr_r;
  assign pc_plus4 = pc_plus4_r;
  assign valid    = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, boot/run FSM, redirect/stall/wait handling and IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          WIDTH     = cpu_pkg::WIDTH,
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] pc_out,
  input  logic [WIDTH-1:0] pc_plus4_in,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic [31:0]      ifid_instr,
  output logic [WIDTH-1:0] ifid_pc_plus4,
  output logic             ifid_valid,
  output logic             misalign_err
);

  fetch_state_e     state_r, next_state_s;
  logic [WIDTH-1:0] pc_r, pc_next_s, redirect_pc_s;
  logic             imem_req_r, misalign_r;
  logic             load_s, hold_s, bubble_s;

  assign redirect_pc_s = {redirect_target[WIDTH-1:2], 2'b00};

  // Next PC, next state and IF/ID control, in redirect > stall > wait > advance order
  always_comb begin
    next_state_s = RUN;
    pc_next_s    = pc_r;
    load_s       = 1'b0;
    hold_s       = 1'b0;
    bubble_s     = 1'b1;
    case (state_r)
      BOOT: begin
        if (redirect) begin
          pc_next_s = redirect_pc_s;
        end else begin
          pc_next_s = pc_r;
        end
      end
      RUN: begin
        if (redirect) begin
          pc_next_s = redirect_pc_s;
        end else if (stall) begin
          hold_s   = 1'b1;
          bubble_s = 1'b0;
        end else if (!imem_valid) begin
          bubble_s = 1'b1;
        end else begin
          pc_next_s = pc_plus4_in;
          load_s    = 1'b1;
          bubble_s  = 1'b0;
        end
      end
      default: begin
        next_state_s = BOOT;
      end
    endcase
  end

  // State, PC, fetch request and sticky misalignment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC[WIDTH-1:0];
      imem_req_r <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pc_r       <= pc_next_s;
      imem_req_r <= (next_state_s == RUN);
      misalign_r <= misalign_r | (redirect & word_misaligned(redirect_target[1:0]));
    end
  end

  if_id_reg #(
    .W   (WIDTH),
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk           (clk),
    .reset         (reset),
    .load          (load_s),
    .hold          (hold_s),
    .bubble        (bubble_s),
    .next_instr    (imem_rdata),
    .next_pc_plus4 (pc_plus4_in),
    .instr         (ifid_instr),
    .pc_plus4      (ifid_pc_plus4),
    .valid         (ifid_valid)
  );

  assign pc_out       = pc_r;
  assign imem_req     = imem_req_r;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle model pushes expected outputs, each test pops and compares.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_out, pc_plus4_in, imem_rdata, redirect_target = 32'h0;
  logic        imem_req, imem_valid = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, misalign_err;

  typedef struct packed {
    logic        req;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        mis;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  logic        m_state, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_pp4;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .pc_plus4_in(pc_plus4_in),
    .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] | 16'h0001};
  endfunction

  // External PC adder and instruction memory
  assign pc_plus4_in = pc_out + 32'd4;
  assign imem_rdata  = instr_at(pc_out);

  function automatic obs_t sample();
    return {imem_req, pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, misalign_err};
  endfunction

  function automatic obs_t model_obs();
    return {m_state, m_pc, m_instr, m_pp4, m_valid, m_mis};
  endfunction

  task automatic m_reset();
    m_state = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic m_bubble();
    m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, push its expectation, then cross the edge
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic iv);
    stall = st; redirect = rd; redirect_target = tgt; imem_valid = iv;
    if (rd && tgt[1:0] != 2'b00) m_mis = 1'b1;
    if (!m_state) begin
      if (rd) m_pc = {tgt[31:2], 2'b00};
      m_bubble();
      m_state = 1'b1;
    end else if (rd) begin
      m_pc = {tgt[31:2], 2'b00};
      m_bubble();
    end else if (st) begin
      m_pc = m_pc;
    end else if (!iv) begin
      m_bubble();
    end else begin
      m_instr = instr_at(m_pc);
      m_pp4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    reset = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(model_obs());
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state obs=%h exp=%h", o, e); end
    reset = 1'b0;
    #2;
    n_cmp++;
    if (imem_req !== 1'b0 || pc_out !== 32'h0) begin
      n_fail++; $display("FAIL boot_cycle req=%b pc=%h exp req=0 pc=0", imem_req, pc_out);
    end
  endtask

  task automatic test_sequential();
    obs_t e, o;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL seq cyc%0d obs=%h exp=%h", i, o, e); end
    end
    n_cmp++;
    if (pc_out !== 32'h8 || ifid_pc_plus4 !== 32'h8 || ifid_valid !== 1'b1) begin
      n_fail++; $display("FAIL seq_end pc=%h pp4=%h v=%b exp pc=8 pp4=8 v=1", pc_out, ifid_pc_plus4, ifid_valid);
    end
  endtask

  task automatic test_stall();
    obs_t e, o;
    for (int i = 0; i < 3; i++) begin
      step(i < 2, 1'b0, 32'h0, 1'b1);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL stall cyc%0d obs=%h exp=%h", i, o, e); end
    end
    n_cmp++;
    if (pc_out !== 32'hC || ifid_instr !== instr_at(32'h8) || ifid_pc_plus4 !== 32'hC) begin
      n_fail++; $display("FAIL stall_release pc=%h instr=%h pp4=%h exp pc=c instr=%h pp4=c",
                         pc_out, ifid_instr, ifid_pc_plus4, instr_at(32'h8));
    end
  endtask

  task automatic test_redirect_stall();
    obs_t e, o;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL redir_pre obs=%h exp=%h", o, e); end
    step(1'b1, 1'b1, 32'h40, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL redir_stall obs=%h exp=%h", o, e); end
    n_cmp++;
    if (pc_out !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      n_fail++; $display("FAIL redir_target pc=%h v=%b instr=%h exp pc=40 v=0 instr=0", pc_out, ifid_valid, ifid_instr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e || ifid_pc_plus4 !== 32'h44) begin
      n_fail++; $display("FAIL redir_first pp4=%h exp=44 obs=%h exp=%h", ifid_pc_plus4, o, e);
    end
  endtask

  task automatic test_imem_wait();
    obs_t e, o;
    step(1'b0, 1'b1, 32'h20, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL wait_redir obs=%h exp=%h", o, e); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, i == 3);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL wait cyc%0d obs=%h exp=%h", i, o, e); end
    end
    n_cmp++;
    if (ifid_instr !== instr_at(32'h20) || ifid_pc_plus4 !== 32'h24 || pc_out !== 32'h24) begin
      n_fail++; $display("FAIL wait_done instr=%h pp4=%h pc=%h exp instr=%h pp4=24 pc=24",
                         ifid_instr, ifid_pc_plus4, pc_out, instr_at(32'h20));
    end
  endtask

  task automatic test_misalign();
    obs_t e, o;
    logic [31:0] tgts [4] = '{32'h103, 32'h0, 32'h200, 32'h0};
    logic        rds  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, rds[i], tgts[i], 1'b1);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL misalign cyc%0d obs=%h exp=%h", i, o, e); end
      if (i == 0) begin
        n_cmp++;
        if (pc_out !== 32'h100 || misalign_err !== 1'b1) begin
          n_fail++; $display("FAIL misalign_set pc=%h err=%b exp pc=100 err=1", pc_out, misalign_err);
        end
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL wrap_redir obs=%h exp=%h", o, e); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e || pc_out !== 32'h0 || ifid_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap pc=%h v=%b exp pc=0 v=1 obs=%h exp=%h", pc_out, ifid_valid, o, e);
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    step(1'b0, 1'b1, 32'h24, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL arst_pre cyc%0d obs=%h exp=%h", i, o, e); end
    end
    n_cmp++;
    if (pc_out !== 32'h2C) begin n_fail++; $display("FAIL arst_pc pc=%h exp=2c", pc_out); end
    #1;
    reset = 1'b1;
    m_reset();
    #1;
    sb.push_back(model_obs());
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL arst_immediate obs=%h exp=%h", o, e); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_boot req=%b exp=0", imem_req); end
    step(1'b0, 1'b1, 32'h80, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e || pc_out !== 32'h80 || ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_redirect pc=%h v=%b exp pc=80 v=0 obs=%h exp=%h", pc_out, ifid_valid, o, e);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL arst_resume obs=%h exp=%h", o, e); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_imem_wait();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
